// File: rtl/thermal_pkg.sv
// Shared thermal types: plant state encoding, temperature type and saturating helpers.
package thermal_pkg;

  localparam int unsigned TEMP_W = 8;

  typedef logic [TEMP_W-1:0] temp_t;
  typedef logic [31:0]       wide_t;

  typedef enum logic [2:0] {
    IDLE,
    HEAT_WAIT,
    HEAT,
    COOL_WAIT,
    COOL,
    CONFLICT
  } plant_state_t;

  // Operands are evaluated in 32 bits, so a temperature plus its step can never wrap.
  function automatic wide_t sat_add(input wide_t a, input wide_t step, input wide_t max);
    wide_t s;
    s = a + step;
    return (s > max) ? max : s;
  endfunction

  function automatic wide_t sat_sub(input wide_t a, input wide_t step);
    return (a < step) ? '0 : (a - step);
  endfunction

endpackage

// File: rtl/thermal_plant_model_if.sv
// Controller <-> plant signal bundle; master is the controller side, slave is the plant.
interface thermal_plant_model_if import thermal_pkg::*; #(
  parameter int unsigned TEMP_W = thermal_pkg::TEMP_W
) ();

  logic              heater_on;
  logic              cooler_on;
  logic [TEMP_W-1:0] ambient_temp;
  logic              load_en;
  logic [TEMP_W-1:0] load_temp;
  logic [TEMP_W-1:0] current_temp;
  logic              temp_changed;
  logic              conflict;

  modport master (
    output heater_on, cooler_on, ambient_temp, load_en, load_temp,
    input  current_temp, temp_changed, conflict
  );

  modport slave (
    input  heater_on, cooler_on, ambient_temp, load_en, load_temp,
    output current_temp, temp_changed, conflict
  );

endinterface

// File: rtl/actuator_delay_timer.sv
// Dead-time counter for one actuator: active once DELAY enabled edges have been seen in a row.
module actuator_delay_timer #(
  parameter int unsigned DELAY = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic active
);

  localparam int unsigned CW = (DELAY < 1) ? 1 : $clog2(DELAY + 1);
  localparam logic [CW-1:0] LIMIT = CW'(DELAY);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  assign active = enable && (count == LIMIT);

endmodule

// File: rtl/thermal_plant_model.sv
// Closed-loop thermal plant: dead-timed heater/cooler steps, saturation, and idle drift to ambient.
module thermal_plant_model import thermal_pkg::*; #(
  parameter int unsigned TEMP_W             = thermal_pkg::TEMP_W,
  parameter int unsigned INIT_TEMP          = 0,
  parameter int unsigned HEATER_CYCLE_DELAY = 10,
  parameter int unsigned COOLER_CYCLE_DELAY = 5,
  parameter int unsigned HEATER_STEP        = 2,
  parameter int unsigned COOLER_STEP        = 3,
  parameter int unsigned DRIFT_PERIOD       = 50,
  parameter int unsigned TEMP_MAX           = 255
) (
  input logic                  clk,
  input logic                  reset,
  thermal_plant_model_if.slave bus
);

  localparam int unsigned DW = (DRIFT_PERIOD < 2) ? 1 : $clog2(DRIFT_PERIOD);
  localparam int unsigned DRIFT_LAST_I = (DRIFT_PERIOD == 0) ? 0 : DRIFT_PERIOD - 1;
  localparam logic [DW-1:0] DRIFT_LAST = DW'(DRIFT_LAST_I);

  plant_state_t      state, state_next;
  logic [TEMP_W-1:0] temp_q, temp_next, prev_temp;
  logic [DW-1:0]     drift_cnt, drift_next;
  logic              changed_q, conflict_q;
  logic              heat_only, cool_only, both_on;
  logic              heat_active, cool_active;

  assign heat_only = bus.heater_on & ~bus.cooler_on;
  assign cool_only = bus.cooler_on & ~bus.heater_on;
  assign both_on   = bus.heater_on &  bus.cooler_on;

  // Each timer is cleared by load or by anything other than its own command alone.
  actuator_delay_timer #(.DELAY(HEATER_CYCLE_DELAY)) u_heater_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (heat_only & ~bus.load_en),
    .clear  (bus.load_en | ~heat_only),
    .active (heat_active)
  );

  actuator_delay_timer #(.DELAY(COOLER_CYCLE_DELAY)) u_cooler_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (cool_only & ~bus.load_en),
    .clear  (bus.load_en | ~cool_only),
    .active (cool_active)
  );

  always_comb begin
    temp_next  = temp_q;
    state_next = state;
    drift_next = '0;
    if (bus.load_en) begin
      temp_next  = bus.load_temp;
      state_next = IDLE;
    end else if (both_on) begin
      state_next = CONFLICT;
    end else if (heat_only) begin
      state_next = heat_active ? HEAT : HEAT_WAIT;
      if (heat_active)
        temp_next = TEMP_W'(sat_add(wide_t'(temp_q), wide_t'(HEATER_STEP), wide_t'(TEMP_MAX)));
    end else if (cool_only) begin
      state_next = cool_active ? COOL : COOL_WAIT;
      if (cool_active)
        temp_next = TEMP_W'(sat_sub(wide_t'(temp_q), wide_t'(COOLER_STEP)));
    end else begin
      state_next = IDLE;
      // Drift only accrues on edges that begin in IDLE, so the first idle edge after a command is not counted.
      if ((state == IDLE) && (DRIFT_PERIOD != 0)) begin
        if (drift_cnt == DRIFT_LAST) begin
          if (temp_q < bus.ambient_temp)
            temp_next = temp_q + TEMP_W'(1);
          else if (temp_q > bus.ambient_temp)
            temp_next = temp_q - TEMP_W'(1);
        end else begin
          drift_next = drift_cnt + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      temp_q     <= TEMP_W'(INIT_TEMP);
      prev_temp  <= TEMP_W'(INIT_TEMP);
      changed_q  <= 1'b0;
      conflict_q <= 1'b0;
      state      <= IDLE;
      drift_cnt  <= '0;
    end else begin
      prev_temp  <= temp_q;
      changed_q  <= (temp_q != prev_temp);
      temp_q     <= temp_next;
      conflict_q <= both_on & ~bus.load_en;
      state      <= state_next;
      drift_cnt  <= drift_next;
    end
  end

  assign bus.current_temp = temp_q;
  assign bus.temp_changed = changed_q;
  assign bus.conflict     = conflict_q;

endmodule

// File: tb/tb_thermal_plant_model.sv
// Random and directed stimulus for thermal_plant_model against a run-length based plant model.
module tb_thermal_plant_model;

  logic clk = 1'b0;
  logic reset;

  thermal_plant_model_if #(.TEMP_W(8)) bus ();

  thermal_plant_model #(
    .TEMP_W             (8),
    .INIT_TEMP          (0),
    .HEATER_CYCLE_DELAY (10),
    .COOLER_CYCLE_DELAY (5),
    .HEATER_STEP        (2),
    .COOLER_STEP        (3),
    .DRIFT_PERIOD       (50),
    .TEMP_MAX           (255)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: temperatures plus run lengths of each input condition.
  int m_temp, m_prev, m_changed, m_conflict;
  int heat_run, cool_run, idle_edges;
  bit m_idle;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_temp = 0; m_prev = 0; m_changed = 0; m_conflict = 0;
    heat_run = 0; cool_run = 0; idle_edges = 0; m_idle = 1'b1;
  endtask

  task automatic model_edge(input bit h, input bit c, input bit ld, input int lt, input int amb);
    m_changed = (m_temp != m_prev) ? 1 : 0;
    m_prev = m_temp;
    m_conflict = 0;
    if (ld) begin
      m_temp = lt; heat_run = 0; cool_run = 0; idle_edges = 0; m_idle = 1'b1;
    end else if (h && c) begin
      m_conflict = 1; heat_run = 0; cool_run = 0; idle_edges = 0; m_idle = 1'b0;
    end else if (h) begin
      cool_run = 0; idle_edges = 0; m_idle = 1'b0;
      heat_run++;
      if (heat_run > 10) m_temp = (m_temp + 2 > 255) ? 255 : m_temp + 2;
    end else if (c) begin
      heat_run = 0; idle_edges = 0; m_idle = 1'b0;
      cool_run++;
      if (cool_run > 5) m_temp = (m_temp < 3) ? 0 : m_temp - 3;
    end else begin
      heat_run = 0; cool_run = 0;
      if (m_idle) begin
        idle_edges++;
        if (idle_edges == 50) begin
          idle_edges = 0;
          if (m_temp < amb) m_temp++;
          else if (m_temp > amb) m_temp--;
        end
      end
      m_idle = 1'b1;
    end
  endtask

  task automatic step(input bit h, input bit c, input bit ld, input int lt, input int amb);
    bus.heater_on    = h;
    bus.cooler_on    = c;
    bus.load_en      = ld;
    bus.load_temp    = 8'(lt);
    bus.ambient_temp = 8'(amb);
    @(posedge clk);
    model_edge(h, c, ld, lt, amb);
    #1;
    check("temp", int'(bus.current_temp), m_temp);
    check("changed", int'(bus.temp_changed), m_changed);
    check("conflict", int'(bus.conflict), m_conflict);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.heater_on = 1'b0; bus.cooler_on = 1'b0; bus.load_en = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    check("rst_temp", int'(bus.current_temp), 0);
    check("rst_changed", int'(bus.temp_changed), 0);
    check("rst_conflict", int'(bus.conflict), 0);
    reset = 1'b0;
  endtask

  initial begin
    bus.heater_on = 1'b0; bus.cooler_on = 1'b0; bus.load_en = 1'b0;
    bus.load_temp = '0; bus.ambient_temp = '0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Heater dead time and first steps
    step(0, 0, 1, 60, 60);
    repeat (10) step(1, 0, 0, 0, 60);
    check("heat_dead", int'(bus.current_temp), 60);
    step(1, 0, 0, 0, 60);
    check("heat_e11", int'(bus.current_temp), 62);
    check("heat_e11_chg", int'(bus.temp_changed), 0);
    step(1, 0, 0, 0, 60);
    check("heat_e12", int'(bus.current_temp), 64);
    check("heat_e12_chg", int'(bus.temp_changed), 1);

    // Cooler dead time, then drop freezes temperature
    step(0, 0, 1, 80, 80);
    repeat (5) step(0, 1, 0, 0, 80);
    check("cool_dead", int'(bus.current_temp), 80);
    step(0, 1, 0, 0, 80);
    check("cool_e6", int'(bus.current_temp), 77);
    step(0, 1, 0, 0, 80);
    check("cool_e7", int'(bus.current_temp), 74);
    repeat (5) step(0, 0, 0, 0, 74);
    check("cool_drop", int'(bus.current_temp), 74);

    // Interrupted heater restarts its dead time
    step(0, 0, 1, 60, 60);
    repeat (7) step(1, 0, 0, 0, 60);
    step(0, 0, 0, 0, 60);
    repeat (10) step(1, 0, 0, 0, 60);
    check("restart_dead", int'(bus.current_temp), 60);
    step(1, 0, 0, 0, 60);
    check("restart_e11", int'(bus.current_temp), 62);

    // Saturation at both ends
    step(0, 0, 1, 250, 0);
    repeat (13) step(1, 0, 0, 0, 0);
    check("sat_hi_255", int'(bus.current_temp), 255);
    step(1, 0, 0, 0, 0);
    check("sat_hi_hold", int'(bus.current_temp), 255);
    step(0, 0, 1, 2, 0);
    repeat (6) step(0, 1, 0, 0, 0);
    check("sat_lo_0", int'(bus.current_temp), 0);
    step(0, 1, 0, 0, 0);
    check("sat_lo_hold", int'(bus.current_temp), 0);

    // Conflict holds temperature
    step(0, 0, 1, 70, 70);
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, 0, 70);
      check("conf_hi", int'(bus.conflict), 1);
    end
    check("conf_temp", int'(bus.current_temp), 70);
    step(0, 0, 0, 0, 70);
    check("conf_rel", int'(bus.conflict), 0);

    // Drift toward ambient
    step(0, 0, 1, 70, 65);
    repeat (49) step(0, 0, 0, 0, 65);
    check("drift_49", int'(bus.current_temp), 70);
    step(0, 0, 0, 0, 65);
    check("drift_50", int'(bus.current_temp), 69);
    repeat (50) step(0, 0, 0, 0, 65);
    check("drift_100", int'(bus.current_temp), 68);
    repeat (60) step(0, 0, 0, 0, 68);
    check("drift_eq", int'(bus.current_temp), 68);

    // Randomized segments
    for (int s = 0; s < 80; s++) begin
      int mode, len, amb;
      mode = int'($urandom_range(0, 6));
      amb  = int'($urandom_range(0, 255));
      case (mode)
        0: begin
          len = int'($urandom_range(1, 120));
          repeat (len) step(0, 0, 0, 0, amb);
        end
        1: begin
          len = int'($urandom_range(1, 40));
          repeat (len) step(1, 0, 0, 0, amb);
        end
        2: begin
          len = int'($urandom_range(1, 40));
          repeat (len) step(0, 1, 0, 0, amb);
        end
        3: begin
          len = int'($urandom_range(1, 10));
          repeat (len) step(1, 1, 0, 0, amb);
        end
        4: step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1,
                int'($urandom_range(0, 255)), amb);
        5: begin
          if ($urandom_range(0, 3) == 0) do_reset();
          else step(0, 0, 1, int'($urandom_range(0, 255)), amb);
        end
        default: begin
          len = int'($urandom_range(5, 60));
          for (int i = 0; i < len; i++)
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0), 0, 0, amb);
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
